// File: rtl/shift_out_ser.sv
// Parallel-to-serial shifter: WIDTH-bit word out one bit per DIV clocks, LSB or MSB first.
// Latency: first bit on data_out the cycle after load is accepted; done one cycle after the last bit.
// Backpressure: ready low while shifting (loads ignored); ena=0 freezes the frame in place.
module shift_out_ser #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             ena,
  output logic             ready,
  output logic             busy,
  output logic             data_out,
  output logic             bit_strobe,
  output logic             done
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             data_out_q, data_out_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      data_out_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      data_out_q   <= data_out_d;
      bit_strobe_q <= bit_strobe_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    data_out_d   = data_out_q;
    bit_strobe_d = 1'b0;
    done_d       = 1'b0;
    // The bit heading the register is always the one on the wire.
    if (MSB_FIRST != 0) shifted = {shreg_q[WIDTH-2:0], 1'b0};
    else                shifted = {1'b0, shreg_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        data_out_d = 1'b0;
        if (load) begin
          state_d      = SHIFT;
          shreg_d      = data_in;
          bit_cnt_d    = '0;
          div_cnt_d    = '0;
          data_out_d   = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
          bit_strobe_d = 1'b1;
        end
      end
      SHIFT: begin
        if (ena) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d    = IDLE;
              data_out_d = 1'b0;
              done_d     = 1'b1;
            end else begin
              bit_cnt_d    = bit_cnt_q + BW'(1);
              shreg_d      = shifted;
              data_out_d   = (MSB_FIRST != 0) ? shifted[WIDTH-1] : shifted[0];
              bit_strobe_d = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign data_out   = data_out_q;
  assign bit_strobe = bit_strobe_q;
  assign done       = done_q;

endmodule

// File: tb/tb_shift_out_ser.sv
// Directed bench for shift_out_ser: LSB-first, MSB-first and DIV=3 instances share stimulus.
module tb_shift_out_ser;

  logic       clk = 1'b0;
  logic       rst, load, ena;
  logic [7:0] data_in;

  logic l_rdy, l_busy, l_dout, l_stb, l_done;
  logic m_rdy, m_busy, m_dout, m_stb, m_done;
  logic d_rdy, d_busy, d_dout, d_stb, d_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  shift_out_ser #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ena(ena),
    .ready(l_rdy), .busy(l_busy), .data_out(l_dout), .bit_strobe(l_stb), .done(l_done));

  shift_out_ser #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ena(ena),
    .ready(m_rdy), .busy(m_busy), .data_out(m_dout), .bit_strobe(m_stb), .done(m_done));

  shift_out_ser #(.WIDTH(8), .DIV(3), .MSB_FIRST(0)) u_div (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ena(ena),
    .ready(d_rdy), .busy(d_busy), .data_out(d_dout), .bit_strobe(d_stb), .done(d_done));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; ena = 1'b1; data_in = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] lsb_seq, msb_seq, ena_seq, rst_seq;
    lsb_seq = 8'b1100_0001;   // index i = i-th bit on the wire for 0xC1 LSB first
    msb_seq = 8'b1000_0011;   // 1,1,0,0,0,0,0,1 for 0xC1 MSB first
    ena_seq = 8'b1100_0001;   // 1,0,0,0,0,0,1,1
    rst_seq = 8'b1000_0001;   // 0x81: 1,0,0,0,0,0,0,1

    @(negedge clk);
    do_reset();
    chk("rst_ready", l_rdy, 1);
    chk("rst_busy", l_busy, 0);
    chk("rst_dout", l_dout, 0);
    chk("rst_strobe", l_stb, 0);
    chk("rst_done", l_done, 0);

    // 0xC1 on the LSB-first and MSB-first instances together
    load = 1'b1; data_in = 8'hC1;
    for (int i = 0; i < 8; i++) begin
      step();
      load = 1'b0;
      chk("lsb_bit", l_dout, lsb_seq[i]);
      chk("lsb_stb", l_stb, 1);
      chk("lsb_busy", l_busy, 1);
      chk("msb_bit", m_dout, msb_seq[i]);
      chk("msb_stb", m_stb, 1);
      if (i == 0) chk("lsb_ready_lo", l_rdy, 0);
    end
    step();
    chk("lsb_done", l_done, 1);
    chk("lsb_ready9", l_rdy, 1);
    chk("lsb_busy9", l_busy, 0);
    chk("lsb_dout9", l_dout, 0);
    chk("msb_done", m_done, 1);
    step();
    chk("lsb_done_pulse", l_done, 0);

    // DIV=3, 0x05
    do_reset();
    load = 1'b1; data_in = 8'h05;
    for (int c = 1; c <= 24; c++) begin
      step();
      load = 1'b0;
      chk("div_bit", d_dout, (8'h05 >> ((c - 1) / 3)) & 8'h01);
      chk("div_stb", d_stb, ((c - 1) % 3) == 0);
      chk("div_busy", d_busy, 1);
      chk("div_done_lo", d_done, 0);
    end
    step();
    chk("div_done", d_done, 1);
    chk("div_busy25", d_busy, 0);

    // Pause after the third bit
    do_reset();
    load = 1'b1; data_in = 8'hC1;
    for (int c = 1; c <= 12; c++) begin
      step();
      load = 1'b0;
      if (c <= 3) begin
        chk("ena_bit", l_dout, ena_seq[c-1]);
        chk("ena_stb", l_stb, 1);
      end else if (c <= 7) begin
        chk("pause_bit", l_dout, 0);
        chk("pause_stb", l_stb, 0);
        chk("pause_busy", l_busy, 1);
      end else begin
        chk("resume_bit", l_dout, ena_seq[c-5]);
        chk("resume_stb", l_stb, 1);
      end
      chk("ena_done_lo", l_done, 0);
      if (c == 3) ena = 1'b0;
      if (c == 7) ena = 1'b1;
    end
    step();
    chk("ena_done", l_done, 1);

    // Load during a frame is ignored; load in the done cycle starts a new frame
    do_reset();
    load = 1'b1; data_in = 8'hFF;
    for (int c = 1; c <= 8; c++) begin
      step();
      load = (c >= 1 && c <= 4);
      data_in = 8'h00;
      chk("ign_bit", l_dout, 1);
      chk("ign_busy", l_busy, 1);
    end
    step();
    chk("ign_done", l_done, 1);
    load = 1'b1; data_in = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      step();
      load = 1'b0;
      chk("b2b_bit", l_dout, 0);
      chk("b2b_busy", l_busy, 1);
      chk("b2b_stb", l_stb, 1);
    end
    step();
    chk("b2b_done", l_done, 1);

    // Reset mid-frame, with a simultaneous load that reset overrides
    do_reset();
    load = 1'b1; data_in = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      step();
      load = 1'b0;
      chk("pre_rst_bit", l_dout, 1);
    end
    rst = 1'b1; load = 1'b1; data_in = 8'h81;
    step();
    chk("mid_rst_dout", l_dout, 0);
    chk("mid_rst_busy", l_busy, 0);
    chk("mid_rst_ready", l_rdy, 1);
    chk("mid_rst_done", l_done, 0);
    rst = 1'b0; load = 1'b1; data_in = 8'h81;
    for (int c = 1; c <= 8; c++) begin
      step();
      load = 1'b0;
      chk("post_rst_bit", l_dout, rst_seq[c-1]);
      chk("post_rst_done_lo", l_done, 0);
    end
    step();
    chk("post_rst_done", l_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
